// File: rtl/slave_split_param_if.sv
// Bus-side bundle for slave_split_param: request, completion and split/re-arbitration signals.
interface slave_split_param_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              sl;
  logic              valid;
  logic              mode;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              err;
  logic              split;
  logic              arbiter_req;
  logic              arbiter_grant;

  modport master (
    output sl, valid, mode, addr, wdata, arbiter_grant,
    input  rdata, ready, err, split, arbiter_req
  );

  modport slave (
    input  sl, valid, mode, addr, wdata, arbiter_grant,
    output rdata, ready, err, split, arbiter_req
  );
endinterface

// File: rtl/slave_split_param.sv
// Parametrised split-transaction bus slave with latency counter, re-arbitration and range error.
// Macro SLAVE_SPLIT_EN enables the split/re-arbitration flow; undefined, the slave holds the bus.
module slave_split_param #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEM_DEPTH = 4096,
  parameter int unsigned LATENCY   = 3
) (
  input  logic              clk,
  input  logic              rst,
  slave_split_param_if.slave bus
);

  localparam int unsigned   IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned   CNT_W     = 8;
  localparam int unsigned   LIM_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAT_CNT   = CNT_W'(LATENCY);
  localparam logic [LIM_W-1:0] DEPTH_LIM = LIM_W'(MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SPLIT   = 3'd1,
    WAIT    = 3'd2,
    ARB_REQ = 3'd3,
    RESP    = 3'd4,
    ERR     = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                mode_q;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic                split_q, split_d;
  logic                arb_req_q, arb_req_d;
  logic [DATA_W-1:0]   rdata_q;
  logic                cap_en;
  logic                mem_we;
  logic                mem_re;
  logic                out_of_range_c;
  logic [IDX_W-1:0]    mem_idx;

  logic [DATA_W-1:0]   mem [MEM_DEPTH];

  assign out_of_range_c = ({1'b0, bus.addr} >= DEPTH_LIM);
  assign mem_idx        = addr_q[IDX_W-1:0];

  // Next-state and pulse/level output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    split_d   = 1'b0;
    arb_req_d = arb_req_q;
    cap_en    = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;

    case (state_q)
      IDLE: begin
        arb_req_d = 1'b0;
        cnt_d     = '0;
        if (bus.sl && bus.valid) begin
          cap_en = 1'b1;
          if (out_of_range_c) begin
            state_d = ERR;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end else begin
`ifdef SLAVE_SPLIT_EN
            state_d = SPLIT;
            split_d = 1'b1;
`else
            state_d = WAIT;
            cnt_d   = CNT_W'(1);
`endif
          end
        end
      end

      SPLIT: begin
        state_d = WAIT;
        cnt_d   = CNT_W'(1);
      end

      WAIT: begin
        if (cnt_q == LAT_CNT) begin
          cnt_d = '0;
`ifdef SLAVE_SPLIT_EN
          state_d   = ARB_REQ;
          arb_req_d = 1'b1;
`else
          // Bus is held: commit the access as soon as the latency has elapsed.
          state_d = RESP;
          ready_d = 1'b1;
          mem_we  = mode_q;
          mem_re  = ~mode_q;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ARB_REQ: begin
        if (bus.arbiter_grant) begin
          state_d   = RESP;
          arb_req_d = 1'b0;
          ready_d   = 1'b1;
          mem_we    = mode_q;
          mem_re    = ~mode_q;
        end
      end

      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, request capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mode_q    <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      split_q   <= 1'b0;
      arb_req_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      split_q   <= split_d;
      arb_req_q <= arb_req_d;
      if (cap_en) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        mode_q  <= bus.mode;
      end
      if (mem_re) begin
        rdata_q <= mem[mem_idx];
      end
    end
  end

  // Storage is not reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_idx] <= wdata_q;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;

`ifdef SLAVE_SPLIT_EN
  assign bus.split       = split_q;
  assign bus.arbiter_req = arb_req_q;
`else
  logic unused_split_path;
  assign bus.split         = 1'b0;
  assign bus.arbiter_req   = 1'b0;
  assign unused_split_path = split_q ^ arb_req_q;
`endif

endmodule

// File: tb/tb_slave_split_param.sv
// Directed table-driven bench for slave_split_param, covering both SLAVE_SPLIT_EN builds.
`timescale 1ns/1ps
module tb_slave_split_param;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MEM_DEPTH = 4096;
`ifdef SLAVE_SPLIT_EN
  localparam int unsigned LAT        = 3;
  localparam bit          SPLIT_FLOW = 1'b1;
`else
  localparam int unsigned LAT        = 2;
  localparam bit          SPLIT_FLOW = 1'b0;
`endif
  localparam int NROWS = 17;

  typedef struct {
    logic        mode;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          delay;
    bit          noise;
    logic        exp_err;
    logic [7:0]  exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t vec [NROWS];

  always #5 clk = ~clk;

  slave_split_param_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  slave_split_param #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MEM_DEPTH(MEM_DEPTH),
    .LATENCY  (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    rst               = 1'b1;
    bus.sl            = 1'b1;
    bus.valid         = 1'b1;
    bus.mode          = 1'b1;
    bus.addr          = 16'h0030;
    bus.wdata         = 8'hEE;
    bus.arbiter_grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("%s_ready%0d", tag, i), 32'(bus.ready), 32'd0);
      check($sformatf("%s_err%0d", tag, i), 32'(bus.err), 32'd0);
      check($sformatf("%s_split%0d", tag, i), 32'(bus.split), 32'd0);
      check($sformatf("%s_arbreq%0d", tag, i), 32'(bus.arbiter_req), 32'd0);
      check($sformatf("%s_rdata%0d", tag, i), 32'(bus.rdata), 32'd0);
    end
    rst               = 1'b0;
    bus.sl            = 1'b0;
    bus.valid         = 1'b0;
    bus.arbiter_grant = 1'b0;
  endtask

  // One request; records cycle numbers (relative to the capture edge) of each response event.
  task automatic run_row(input int idx);
    vec_t       v;
    int         rdy_cyc, rdy_cnt, spl_cyc, spl_cnt, arb_cyc, arb_cnt;
    int         exp_rdy, exp_spl, exp_arb, exp_arbcnt;
    logic       err_v;
    logic [7:0] rd_v;
    bit         inrange_split;
    v       = vec[idx];
    rdy_cyc = 0; rdy_cnt = 0; spl_cyc = 0; spl_cnt = 0; arb_cyc = 0; arb_cnt = 0;
    err_v   = 1'bx;
    rd_v    = 8'hxx;

    bus.sl            = 1'b1;
    bus.valid         = 1'b1;
    bus.mode          = v.mode;
    bus.addr          = v.addr;
    bus.wdata         = v.wdata;
    bus.arbiter_grant = (v.delay == 0);
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.split) begin
        spl_cnt++;
        if (spl_cyc == 0) spl_cyc = k;
      end
      if (bus.arbiter_req) begin
        arb_cnt++;
        if (arb_cyc == 0) arb_cyc = k;
      end
      if (bus.ready) begin
        rdy_cnt++;
        if (rdy_cyc == 0) begin
          rdy_cyc = k;
          err_v   = bus.err;
          rd_v    = bus.rdata;
        end
      end
      bus.sl    = 1'b0;
      bus.valid = 1'b0;
      if (v.noise && k == 2) begin
        bus.sl    = 1'b1;
        bus.valid = 1'b1;
        bus.mode  = 1'b1;
        bus.addr  = v.addr + 16'd1;
        bus.wdata = ~v.wdata;
      end
      if (arb_cyc != 0 && k == arb_cyc + v.delay) bus.arbiter_grant = 1'b1;
      if (rdy_cyc != 0) bus.arbiter_grant = 1'b0;
      if (rdy_cyc != 0 && k >= rdy_cyc + 3) break;
    end

    inrange_split = SPLIT_FLOW && !v.exp_err;
    exp_rdy    = v.exp_err ? 1 : (SPLIT_FLOW ? 3 + int'(LAT) + v.delay : 1 + int'(LAT));
    exp_spl    = inrange_split ? 1 : 0;
    exp_arb    = inrange_split ? 2 + int'(LAT) : 0;
    exp_arbcnt = inrange_split ? v.delay + 1 : 0;

    check($sformatf("row%0d_ready_cycle", idx), 32'(rdy_cyc), 32'(exp_rdy));
    check($sformatf("row%0d_ready_count", idx), 32'(rdy_cnt), 32'd1);
    check($sformatf("row%0d_err", idx), 32'(err_v), 32'(v.exp_err));
    check($sformatf("row%0d_rdata", idx), 32'(rd_v), 32'(v.exp_rdata));
    check($sformatf("row%0d_split_cycle", idx), 32'(spl_cyc), 32'(exp_spl));
    check($sformatf("row%0d_split_count", idx), 32'(spl_cnt), 32'(exp_spl));
    check($sformatf("row%0d_arbreq_cycle", idx), 32'(arb_cyc), 32'(exp_arb));
    check($sformatf("row%0d_arbreq_count", idx), 32'(arb_cnt), 32'(exp_arbcnt));
  endtask

  // Write to 0x0020 aborted by reset on its last pre-commit cycle (grant offered at the same edge).
  task automatic abort_write();
    int   abort_k, rcnt;
    logic arb_seen;
    abort_k  = SPLIT_FLOW ? 2 + int'(LAT) : int'(LAT);
    rcnt     = 0;
    arb_seen = 1'b0;
    bus.sl            = 1'b1;
    bus.valid         = 1'b1;
    bus.mode          = 1'b1;
    bus.addr          = 16'h0020;
    bus.wdata         = 8'hDD;
    bus.arbiter_grant = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.ready) rcnt++;
      if (k == abort_k) arb_seen = bus.arbiter_req;
      if (k == abort_k + 1) begin
        check("abort_split_in_rst", 32'(bus.split), 32'd0);
        check("abort_arbreq_in_rst", 32'(bus.arbiter_req), 32'd0);
        check("abort_rdata_in_rst", 32'(bus.rdata), 32'd0);
      end
      bus.sl    = 1'b0;
      bus.valid = 1'b0;
      if (k == abort_k) begin
        rst               = 1'b1;
        bus.arbiter_grant = 1'b1;
      end
      if (k == abort_k + 2) begin
        rst               = 1'b0;
        bus.arbiter_grant = 1'b0;
      end
    end
    check("abort_arbreq_before_rst", 32'(arb_seen), 32'(SPLIT_FLOW));
    check("abort_ready_count", 32'(rcnt), 32'd0);
  endtask

  initial begin
    //          mode   addr      wdata  dly noise err   rdata
    vec[0]  = '{1'b1, 16'h0010, 8'hA5, 0, 1'b0, 1'b0, 8'h00};
    vec[1]  = '{1'b0, 16'h0010, 8'h00, 0, 1'b0, 1'b0, 8'hA5};
    vec[2]  = '{1'b1, 16'h0005, 8'h3C, 4, 1'b0, 1'b0, 8'hA5};
    vec[3]  = '{1'b0, 16'h0005, 8'h00, 4, 1'b0, 1'b0, 8'h3C};
    vec[4]  = '{1'b0, 16'h1000, 8'h00, 0, 1'b0, 1'b1, 8'h3C};
    vec[5]  = '{1'b1, 16'h0FFF, 8'h77, 1, 1'b0, 1'b0, 8'h3C};
    vec[6]  = '{1'b0, 16'h0FFF, 8'h00, 0, 1'b0, 1'b0, 8'h77};
    vec[7]  = '{1'b1, 16'hFFFF, 8'h99, 0, 1'b0, 1'b1, 8'h77};
    vec[8]  = '{1'b0, 16'h0010, 8'h00, 2, 1'b0, 1'b0, 8'hA5};
    vec[9]  = '{1'b1, 16'h0041, 8'h56, 0, 1'b0, 1'b0, 8'hA5};
    vec[10] = '{1'b1, 16'h0040, 8'h12, 0, 1'b1, 1'b0, 8'hA5};
    vec[11] = '{1'b0, 16'h0041, 8'h00, 1, 1'b0, 1'b0, 8'h56};
    vec[12] = '{1'b0, 16'h0040, 8'h00, 0, 1'b0, 1'b0, 8'h12};
    vec[13] = '{1'b1, 16'h0020, 8'h66, 0, 1'b0, 1'b0, 8'h12};
    vec[14] = '{1'b1, 16'h0030, 8'h11, 0, 1'b0, 1'b0, 8'h12};
    vec[15] = '{1'b0, 16'h0020, 8'h00, 0, 1'b0, 1'b0, 8'h66};
    vec[16] = '{1'b0, 16'h0030, 8'h00, 0, 1'b0, 1'b0, 8'h11};

    bus.mode  = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    do_reset("init_rst");

    for (int i = 0; i <= 14; i++) run_row(i);

    abort_write();
    do_reset("mid_rst");

    for (int i = 15; i < NROWS; i++) run_row(i);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
